// File: rtl/mcc_mem_responder_pkg.sv
// Shared constants for the memory-side responder: MMIO offsets, default region bases,
// the mtimecmp reset value and the byte-lane merge helper.
package mcc_mem_responder_pkg;

  localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFF_GPIO        = 8'h10;
  localparam logic [7:0] OFF_STATUS      = 8'h14;
  localparam logic [7:0] OFF_PRESCALE    = 8'h18;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = wen[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mcc_mem_responder_timer.sv
// Machine timer block: 64-bit mtime/mtimecmp, registered timer_irq and its MMIO read mux.
// Optional prescaler (PRESCALE at 0x18) is built when MCC_RESP_PRESCALER_EN is defined.
module mcc_timer
  import mcc_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sel,
  input  logic [5:0]  i_word,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wen,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_irq;
  logic        w_wr;
  logic        w_tick;

  assign w_wr = i_sel && (i_wen != 4'b0000);

`ifdef MCC_RESP_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic [31:0] w_ps_merged;

  assign w_tick      = (r_pcnt == r_prescale);
  assign w_ps_merged = lane_merge({16'h0000, r_prescale}, i_wdata, {2'b00, i_wen[1:0]});

  // A PRESCALE write restarts the divider on the same edge it lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else if (w_wr && (i_word == OFF_PRESCALE[7:2])) begin
      r_prescale <= w_ps_merged[15:0];
      r_pcnt     <= '0;
    end else if (w_tick) begin
      r_pcnt     <= '0;
    end else begin
      r_pcnt     <= r_pcnt + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Software writes to mtime take priority over the increment for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (w_wr && (i_word == OFF_MTIME_LO[7:2])) begin
      r_mtime[31:0] <= lane_merge(r_mtime[31:0], i_wdata, i_wen);
    end else if (w_wr && (i_word == OFF_MTIME_HI[7:2])) begin
      r_mtime[63:32] <= lane_merge(r_mtime[63:32], i_wdata, i_wen);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
      if (w_wr && (i_word == OFF_MTIMECMP_LO[7:2])) begin
        r_mtimecmp[31:0] <= lane_merge(r_mtimecmp[31:0], i_wdata, i_wen);
      end else if (w_wr && (i_word == OFF_MTIMECMP_HI[7:2])) begin
        r_mtimecmp[63:32] <= lane_merge(r_mtimecmp[63:32], i_wdata, i_wen);
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_word)
      OFF_MTIME_LO[7:2]:    o_rdata = r_mtime[31:0];
      OFF_MTIME_HI[7:2]:    o_rdata = r_mtime[63:32];
      OFF_MTIMECMP_LO[7:2]: o_rdata = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI[7:2]: o_rdata = r_mtimecmp[63:32];
      OFF_STATUS[7:2]:      o_rdata = {31'd0, r_irq};
`ifdef MCC_RESP_PRESCALER_EN
      OFF_PRESCALE[7:2]:    o_rdata = {16'd0, r_prescale};
`endif
      default:              o_rdata = '0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/mcc_mem_responder.sv
// Memory-side responder: address decode, byte-lane RAM, GPIO register and the timer block.
// Optional MMIO prescaler is enabled by defining MCC_RESP_PRESCALER_EN.
module mcc_mem_responder
  import mcc_mem_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wenable,
  output logic [31:0] mem_rdata,
  output logic        timer_irq,
  output logic [7:0]  gpio_out
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0] r_ram [RAM_WORDS];
  logic [7:0]  r_gpio;
  logic [31:0] w_ram_off;
  logic [AW-1:0] w_ram_idx;
  logic        w_ram_hit;
  logic        w_mmio_hit;
  logic [5:0]  w_word;
  logic [31:0] w_timer_rdata;

  // Offset compare against the region size handles a non-zero RAM_BASE without wrap issues.
  assign w_ram_off  = mem_addr - RAM_BASE;
  assign w_ram_hit  = ({1'b0, w_ram_off} < RAM_BYTES);
  assign w_ram_idx  = w_ram_off[AW+1:2];
  assign w_mmio_hit = !w_ram_hit && (mem_addr[31:8] == MMIO_BASE[31:8]);
  assign w_word     = mem_addr[7:2];

  always_ff @(posedge clk) begin
    if (w_ram_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_wenable[k]) begin
          r_ram[w_ram_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio <= '0;
    end else if (w_mmio_hit && (w_word == OFF_GPIO[7:2]) && mem_wenable[0]) begin
      r_gpio <= mem_wdata[7:0];
    end
  end

  mcc_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sel   (w_mmio_hit),
    .i_word  (w_word),
    .i_wdata (mem_wdata),
    .i_wen   (mem_wenable),
    .o_rdata (w_timer_rdata),
    .o_irq   (timer_irq)
  );

  always_comb begin
    mem_rdata = '0;
    if (w_ram_hit) begin
      mem_rdata = r_ram[w_ram_idx];
    end else if (w_mmio_hit) begin
      mem_rdata = (w_word == OFF_GPIO[7:2]) ? {24'd0, r_gpio} : w_timer_rdata;
    end
  end

  assign gpio_out = r_gpio;

endmodule

// File: tb/tb_mcc_mem_responder.sv
// Self-checking bench for mcc_mem_responder with a cycle-level behavioural model.
module tb_mcc_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_rdata;
  logic        timer_irq;
  logic [7:0]  gpio_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_MTLO  = 32'h8000_0000;
  localparam logic [31:0] A_MTHI  = 32'h8000_0004;
  localparam logic [31:0] A_CMPLO = 32'h8000_0008;
  localparam logic [31:0] A_CMPHI = 32'h8000_000C;
  localparam logic [31:0] A_GPIO  = 32'h8000_0010;
  localparam logic [31:0] A_STAT  = 32'h8000_0014;
  localparam logic [31:0] A_PS    = 32'h8000_0018;

  // Behavioural model state
  logic [7:0]  m_ram [16384];
  logic [63:0] m_mt;
  logic [63:0] m_cmp;
  logic        m_irq;
  logic [7:0]  m_gpio;
  logic [15:0] m_ps;
  logic [15:0] m_pcnt;

  always #5 clk = ~clk;

  mcc_mem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wenable (mem_wenable),
    .mem_rdata   (mem_rdata),
    .timer_irq   (timer_irq),
    .gpio_out    (gpio_out)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] we);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = we[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mt = 64'd0; m_cmp = '1; m_irq = 1'b0; m_gpio = 8'd0; m_ps = 16'd0; m_pcnt = 16'd0;
  endtask

  task automatic model_edge();
    logic [63:0] nmt;
    logic [63:0] ncmp;
    logic [15:0] nps;
    logic [15:0] npcnt;
    logic [31:0] tmp;
    bit tick;
    nmt = m_mt; ncmp = m_cmp; nps = m_ps;
`ifdef MCC_RESP_PRESCALER_EN
    tick  = (m_pcnt == m_ps);
    npcnt = tick ? 16'd0 : m_pcnt + 16'd1;
`else
    tick  = 1'b1;
    npcnt = m_pcnt;
`endif
    if (tick) nmt = m_mt + 64'd1;
    if (mem_wenable != 4'd0) begin
      if (mem_addr < 32'h4000) begin
        for (int k = 0; k < 4; k++)
          if (mem_wenable[k]) m_ram[{mem_addr[13:2], 2'(k)}] = mem_wdata[8*k +: 8];
      end else if (mem_addr[31:8] == 24'h80_0000) begin
        case (mem_addr[7:0] & 8'hFC)
          8'h00: nmt  = {m_mt[63:32], merge(m_mt[31:0], mem_wdata, mem_wenable)};
          8'h04: nmt  = {merge(m_mt[63:32], mem_wdata, mem_wenable), m_mt[31:0]};
          8'h08: ncmp = {m_cmp[63:32], merge(m_cmp[31:0], mem_wdata, mem_wenable)};
          8'h0C: ncmp = {merge(m_cmp[63:32], mem_wdata, mem_wenable), m_cmp[31:0]};
          8'h10: if (mem_wenable[0]) m_gpio = mem_wdata[7:0];
`ifdef MCC_RESP_PRESCALER_EN
          8'h18: begin
            tmp   = merge({16'd0, m_ps}, mem_wdata, {2'b00, mem_wenable[1:0]});
            nps   = tmp[15:0];
            npcnt = 16'd0;
          end
`endif
          default: ;
        endcase
      end
    end
    m_irq = (m_mt >= m_cmp);
    m_mt = nmt; m_cmp = ncmp; m_ps = nps; m_pcnt = npcnt;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'h4000)
      return {m_ram[{a[13:2], 2'd3}], m_ram[{a[13:2], 2'd2}], m_ram[{a[13:2], 2'd1}], m_ram[{a[13:2], 2'd0}]};
    if (a[31:8] != 24'h80_0000) return 32'd0;
    case (a[7:0] & 8'hFC)
      8'h00: return m_mt[31:0];
      8'h04: return m_mt[63:32];
      8'h08: return m_cmp[31:0];
      8'h0C: return m_cmp[63:32];
      8'h10: return {24'd0, m_gpio};
      8'h14: return {31'd0, m_irq};
`ifdef MCC_RESP_PRESCALER_EN
      8'h18: return {16'd0, m_ps};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock: model follows the DUT edge, returns at the following negedge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    mem_addr = a; mem_wdata = d; mem_wenable = we;
    step();
    mem_wenable = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; mem_wenable = 4'd0;
    #1 d = mem_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b1; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wenable = 4'd0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (gpio_out !== 8'd0) begin failures++; $display("FAIL reset_gpio got=%h exp=00", gpio_out); end
    rd(A_CMPLO, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmplo got=%h exp=ffffffff", d); end
    rd(A_MTLO, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_mtime_held got=%h exp=0", d); end
    rst_n = 1'b1;
  endtask

  task automatic test_timer_count();
    logic [31:0] d;
    repeat (10) step();
    rd(A_MTLO, d);
    checks++; if (d !== 32'd10 || d !== model_read(A_MTLO)) begin failures++; $display("FAIL count10 got=%0d exp=10", d); end
    wr(A_MTLO, 32'hFFFF_FFFF, 4'hF);
    wr(A_MTHI, 32'd0, 4'hF);
    rd(A_MTLO, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL write_wins_lo got=%h exp=ffffffff", d); end
    step();
    rd(A_MTHI, d);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL carry_hi got=%h exp=1", d); end
    rd(A_MTLO, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL carry_lo got=%h exp=0", d); end
  endtask

  task automatic test_ram_lanes();
    logic [31:0] d;
    wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h102, 32'h0000_00AA, 4'b0001);
    rd(32'h100, d);
    checks++; if (d !== 32'hDEAD_BEAA) begin failures++; $display("FAIL ram_lanes got=%h exp=deadbeaa", d); end
    rd(32'h103, d);
    checks++; if (d !== 32'hDEAD_BEAA) begin failures++; $display("FAIL ram_unaligned got=%h exp=deadbeaa", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(32'h0, 32'h1122_3344, 4'hF);
    wr(32'h4000_0000, 32'h1234_5678, 4'hF);
    wr(32'h4000, 32'hCAFE_F00D, 4'hF);
    rd(32'h4000_0000, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
    rd(32'h0, d);
    checks++; if (d !== 32'h1122_3344) begin failures++; $display("FAIL ram_word0_kept got=%h exp=11223344", d); end
    rd(32'h4000, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL past_ram_end got=%h exp=0", d); end
    step();
    wr(32'h3FFC, 32'hA5A5_0F0F, 4'hF);
    rd(32'h3FFC, d);
    checks++; if (d !== 32'hA5A5_0F0F) begin failures++; $display("FAIL ram_last_word got=%h exp=a5a50f0f", d); end
    wr(32'h8000_001C, 32'hFFFF_FFFF, 4'hF);
    rd(32'h8000_001C, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL mmio_hole got=%h exp=0", d); end
    wr(A_GPIO, 32'hFFFF_FF3C, 4'hF);
    rd(A_GPIO, d);
    checks++; if (d !== 32'h0000_003C) begin failures++; $display("FAIL gpio_upper got=%h exp=3c", d); end
`ifndef MCC_RESP_PRESCALER_EN
    step();
    wr(A_PS, 32'h0000_0003, 4'hF);
    rd(A_PS, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL no_prescale_reg got=%h exp=0", d); end
`endif
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(A_CMPHI, 32'd0, 4'hF);
    wr(A_CMPLO, 32'd20, 4'hF);
    wr(A_MTHI, 32'd0, 4'hF);
    wr(A_MTLO, 32'd0, 4'hF);
    for (int i = 1; i <= 22; i++) begin
      step();
      checks++;
      if (timer_irq !== (i >= 21) || timer_irq !== m_irq) begin
        failures++; $display("FAIL irq_rise cyc=%0d got=%b exp=%b", i, timer_irq, (i >= 21));
      end
      if (i == 20) begin
        rd(A_MTLO, d);
        checks++; if (d !== 32'd20) begin failures++; $display("FAIL irq_mtime20 got=%0d exp=20", d); end
      end
      if (i == 5 || i == 21) begin
        rd(A_STAT, d);
        checks++; if (d !== {31'd0, (i >= 21)}) begin failures++; $display("FAIL status cyc=%0d got=%h exp=%0d", i, d, (i >= 21)); end
      end
    end
    wr(A_CMPLO, 32'd1000, 4'hF);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", timer_irq); end
    step();
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", timer_irq); end
    rd(A_STAT, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL status_clear got=%h exp=0", d); end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    logic [31:0] d;
    logic [31:0] a;
    pool = '{32'h0, 32'h8, 32'h100, 32'h200, 32'h2000, 32'h3FFC};
    for (int i = 0; i < 6; i++) wr(pool[i], $urandom, 4'hF);
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0: wr(pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
        1: begin
          a = pool[$urandom_range(0, 5)];
          rd(a, d);
          checks++; if (d !== model_read(a)) begin failures++; $display("FAIL rand_ram a=%h got=%h exp=%h", a, d, model_read(a)); end
          step();
        end
        2: wr(A_GPIO, $urandom, 4'($urandom_range(0, 15)));
        3: begin
          a = 32'h8000_0000 | 32'({$urandom_range(0, 7), 2'b00});
          rd(a, d);
          checks++; if (d !== model_read(a)) begin failures++; $display("FAIL rand_mmio a=%h got=%h exp=%h", a, d, model_read(a)); end
          step();
        end
        4: wr(($urandom_range(0, 1) != 0) ? A_CMPLO : A_CMPHI, 32'($urandom_range(0, 400)), 4'hF);
        default: wr(32'h4000_0000 + 32'($urandom_range(0, 255)), $urandom, 4'hF);
      endcase
      checks++;
      if (timer_irq !== m_irq || gpio_out !== m_gpio) begin
        failures++; $display("FAIL rand_outputs it=%0d irq=%b/%b gpio=%h/%h", it, timer_irq, m_irq, gpio_out, m_gpio);
      end
    end
  endtask

`ifdef MCC_RESP_PRESCALER_EN
  task automatic test_prescaler();
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] d;
    wr(A_PS, 32'h0000_0003, 4'b0011);
    rd(A_PS, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL prescale_reg got=%h exp=3", d); end
    rd(A_MTLO, t0);
    repeat (40) step();
    rd(A_MTLO, t1);
    checks++; if (t1 - t0 !== 32'd10 || t1 !== model_read(A_MTLO)) begin failures++; $display("FAIL prescale_rate got=%0d exp=10", t1 - t0); end
    wr(A_PS, 32'd0, 4'b0011);
  endtask
`endif

  task automatic test_reset_midop();
    logic [31:0] d;
    wr(A_GPIO, 32'h0000_005A, 4'h1);
    wr(A_CMPHI, 32'd0, 4'hF);
    wr(A_CMPLO, 32'd0, 4'hF);
    step();
    checks++; if (timer_irq !== 1'b1 || gpio_out !== 8'h5A) begin failures++; $display("FAIL midop_pre irq=%b gpio=%h exp=1/5a", timer_irq, gpio_out); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL async_irq got=%b exp=0", timer_irq); end
    checks++; if (gpio_out !== 8'd0) begin failures++; $display("FAIL async_gpio got=%h exp=00", gpio_out); end
    step();
    step();
    rst_n = 1'b1;
    rd(A_CMPLO, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL post_rst_cmplo got=%h exp=ffffffff", d); end
    rd(A_CMPHI, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL post_rst_cmphi got=%h exp=ffffffff", d); end
    rd(A_MTLO, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL post_rst_mtime got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_timer_count();
    test_ram_lanes();
    test_unmapped();
    test_irq();
    test_random();
`ifdef MCC_RESP_PRESCALER_EN
    test_prescaler();
`endif
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcc_mem_responder.md
Name: mcc_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's single-port bus (mem_addr/mem_wdata/mem_wenable/mem_rdata).
- Provides a word-organised RAM with byte-lane writes plus a small MMIO region containing a 64-bit machine timer, a timer interrupt and an 8-bit GPIO output register.
- Read data is combinational, because the CPU samples mem_rdata in the same cycle it drives mem_addr. Writes commit on the clock edge.

Parameters:
- RAM_WORDS, 4096, RAM depth in 32-bit words (power of two).
- RAM_BASE, 32'h0000_0000, byte base address of the RAM region.
- MMIO_BASE, 32'h8000_0000, byte base address of the 256-byte MMIO region.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  byte address from CPU
- mem_wdata  in  32  write data (lane k = bits 8k+7:8k)
- mem_wenable  in  4  per-byte write enables; 4'b0000 = read/idle
- mem_rdata  out  32  read data, combinational from mem_addr
- timer_irq  out  1  registered timer interrupt level
- gpio_out  out  8  GPIO output register

Behaviour:
- Decode:
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS.
  - MMIO hit: addr[31:8] == MMIO_BASE[31:8].
  - Anything else is unmapped: reads return 0, writes are ignored.
- Addressing: mem_addr[1:0] is ignored in every region. Lane k of mem_wdata writes byte k of the addressed word. The CPU performs no lane shifting and the responder performs none either.
- RAM:
  - Index is (addr - RAM_BASE)[log2(RAM_WORDS)+1:2].
  - Read is asynchronous.
  - Write is on posedge clk, per enabled lane.
  - Contents are not reset.
  - Read-during-write to the same word returns the old word in that cycle.
- MMIO map (offset = addr[7:0], word aligned):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 GPIO (bits 7:0 R/W; bits 31:8 read 0, write ignored)
  - 0x14 STATUS (bit0 = timer_irq, read-only)
  - Other offsets read 0 and ignore writes.
- Reset values (async, on rst_n low): mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, gpio_out = 0, timer_irq = 0. These values are held while rst_n is low.
- mtime:
  - Increments by 1 every clk after reset release.
  - Wraps from 2^64-1 to 0.
  - Carry propagates from LO into HI in the same cycle.
- Write to MTIME_LO/HI: in that cycle mtime <= current mtime with enabled lanes of the selected half replaced by wdata. No increment occurs that cycle; the write wins. Increment resumes the next cycle.
- Write to MTIMECMP_LO/HI: lane-merged into the selected half. Takes effect on the next edge.
- timer_irq:
  - Registered as timer_irq <= (mtime >= mtimecmp), unsigned 64-bit, using pre-edge register values.
  - Latency is one clk after the comparison becomes true.
  - Cleared only by raising mtimecmp or lowering mtime.
- Reads of MTIME return the current register value, with no snapshot/latching between halves. Software must use the hi-lo-hi read sequence.
- An unaligned mem_addr gives no error indication.

Optional Feature:
- Macro: MCC_RESP_PRESCALER_EN.
- Defined:
  - Adds PRESCALE register at offset 0x18: bits 15:0 R/W, reset 0.
  - Adds internal 16-bit counter pcnt, reset 0.
  - Each clk: if pcnt == PRESCALE then pcnt <= 0 and mtime increments; else pcnt <= pcnt+1.
  - A write to PRESCALE clears pcnt in the same edge.
  - An MTIME write still suppresses the increment that cycle and leaves pcnt advancing.
- Undefined: offset 0x18 reads 0; mtime increments every clk.

Decomposition:
- Shared package/header holds:
  - MMIO offset constants (MTIME_LO .. PRESCALE).
  - Default region bases.
  - mtimecmp reset constant.
- One natural sub-module: mcc_timer. It contains mtime, mtimecmp, the optional prescaler, timer_irq and its read mux.
- The top level keeps address decode, the RAM and the GPIO register.

Test Plan:
- RAM byte lanes: write 32'hDEADBEEF, wenable 4'b1111 at 0x100; then 32'h000000AA, wenable 4'b0001 at 0x102. Read 0x100 -> 32'hDEADBEAA.
- Unmapped: write 32'h1234_5678 at 0x4000_0000. Read it -> 0. RAM word 0 is unchanged.
- Timer count: release reset, wait 10 clk, read MTIME_LO -> 10 (±1 per sampling edge, checked exactly against the bench's edge count). Write MTIME_LO = 32'hFFFF_FFFF and MTIME_HI = 0, then 1 clk later -> MTIME_HI = 1, MTIME_LO = 0.
- Interrupt: set mtimecmp = 20 with mtime = 0. timer_irq rises exactly on the edge after mtime reaches 20. Write MTIMECMP_LO = 1000 -> timer_irq falls one clk later. STATUS bit0 tracks it.
- Reset mid-operation: assert rst_n low asynchronously between edges with timer_irq = 1 and gpio = 8'h5A. Outputs go to 0 immediately, without waiting for clk. mtimecmp reads all-ones after release.
- Prescaler (with MCC_RESP_PRESCALER_EN): PRESCALE = 3 -> mtime advances by 1 every 4 clk. Over 40 clk, mtime advances by 10.
